// File: rtl/if_pc_fetch_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Optional build macro: IF_REDIRECT_REG_EN (registered EX redirect).
`ifndef RNG_64
`define RNG_64 63:0
`endif

package if_pc_fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [`RNG_64] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Word-aligned memory address for a (possibly halfword-aligned) PC
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_pc_fetch_if.sv
// Instruction-memory request/response bus (req/gnt/rvalid).
interface if_pc_fetch_if
  import if_pc_fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF
);

  logic               req;
  logic [XLEN-1:0]    addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_pc_fetch_hold_buf.sv
// Single-entry {pc, instr} skid register; clear has priority over load.
module if_pc_fetch_hold_buf
  import if_pc_fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [XLEN-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_pc_fetch.sv
// Fetch-stage PC generator: one outstanding imem request, EX redirects, stall skid.
// Define IF_REDIRECT_REG_EN to register the EX redirect before it acts.
module if_pc_fetch
  import if_pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_stall,
  input  logic               i_ex_jump_taken,
  input  logic               i_ex_branch_taken,
  input  logic [XLEN-1:0]    i_ex_jump_target,
  input  logic [XLEN-1:0]    i_ex_branch_target,
  if_pc_fetch_if.master      imem,
  output logic               o_if_valid,
  output logic [XLEN-1:0]    o_if_pc,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic               o_flush
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               if_valid_q, if_valid_d;
  logic [XLEN-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;

  logic               redir_c;
  logic [XLEN-1:0]    tgt_raw_c, tgt_c;
  logic               req_c, flush_c, hb_load_c, hb_clear_c;
  logic               hb_valid;
  logic [XLEN-1:0]    hb_pc;
  logic [INSTR_W-1:0] hb_instr;

  // Jump wins over branch; bit0 of the target is always cleared
  assign tgt_raw_c = (i_ex_jump_taken ? i_ex_jump_target : i_ex_branch_target) & ~XLEN'(1);

`ifdef IF_REDIRECT_REG_EN
  logic            redir_q, redir_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  always_comb begin
    redir_d = i_ex_jump_taken | i_ex_branch_taken;
    tgt_d   = tgt_raw_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      redir_q <= redir_d;
      tgt_q   <= tgt_d;
    end
  end

  assign redir_c = redir_q;
  assign tgt_c   = tgt_q;
`else
  assign redir_c = i_ex_jump_taken | i_ex_branch_taken;
  assign tgt_c   = tgt_raw_c;
`endif

  if_pc_fetch_hold_buf #(.INSTR_W(INSTR_W)) u_hold_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hb_load_c),
    .clear    (hb_clear_c),
    .pc_in    (req_pc_q),
    .instr_in (imem.rdata),
    .valid    (hb_valid),
    .pc       (hb_pc),
    .instr    (hb_instr)
  );

  // Next-state, request and IF/ID output logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    req_c      = 1'b0;
    flush_c    = 1'b0;
    hb_load_c  = 1'b0;
    hb_clear_c = 1'b0;

    if (redir_c) begin
      flush_c    = 1'b1;
      pc_d       = tgt_c;
      if_valid_d = 1'b0;
      hb_clear_c = 1'b1;
      state_d    = FETCH;
      if ((state_q == WAIT || state_q == DRAIN) && !imem.rvalid) state_d = DRAIN;
    end else begin
      // A displayed instruction is consumed on any unstalled cycle
      if (!i_stall) if_valid_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          req_c = 1'b1;
          if (imem.gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid && i_stall) begin
            hb_load_c = 1'b1;
            state_d   = HOLD;
          end else if (imem.rvalid) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem.rdata;
            req_c      = 1'b1;
            if (imem.gnt) begin
              req_pc_d = pc_q;
              pc_d     = pc_q + XLEN'(4);
            end else begin
              state_d = FETCH;
            end
          end
        end
        HOLD: begin
          if (!i_stall) begin
            if_valid_d = hb_valid;
            if_pc_d    = hb_pc;
            if_instr_d = hb_instr;
            hb_clear_c = 1'b1;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (imem.rvalid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem.req   = req_c;
  assign imem.addr  = word_addr(pc_q);
  assign o_flush    = flush_c;
  assign o_if_valid = if_valid_q;
  assign o_if_pc    = if_pc_q;
  assign o_if_instr = if_instr_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Scoreboard bench for if_pc_fetch: memory model returns rdata = addr[31:0].
module tb_if_pc_fetch;
  import if_pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic [63:0] jt = '0;
  logic [63:0] bt = '0;
  logic        o_if_valid;
  logic [63:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        o_flush;

  if_pc_fetch_if #(.INSTR_W(32)) imem ();

  if_pc_fetch dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_stall            (i_stall),
    .i_ex_jump_taken    (jump),
    .i_ex_branch_taken  (branch),
    .i_ex_jump_target   (jt),
    .i_ex_branch_target (bt),
    .imem               (imem),
    .o_if_valid         (o_if_valid),
    .o_if_pc            (o_if_pc),
    .o_if_instr         (o_if_instr),
    .o_flush            (o_flush)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          allow = 0;
  int          n_gnt = 0;
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [63:0] paddr = '0;
  logic [63:0] exp_addr[$];
  logic [95:0] exp_out[$];
  int          gnt_cyc[$];

  // Memory grants only while the bench has issued grant credit
  assign imem.gnt = imem.req && rst_n && (n_gnt < allow);

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: fixed latency, one outstanding, not reset with the DUT
  always @(posedge clk) begin
    imem.rvalid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= paddr[31:0];
        pend        <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem.req && imem.gnt) begin
      n_gnt <= n_gnt + 1;
      if (lat == 1) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= imem.addr[31:0];
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem.addr;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [63:0] pc);
    logic [63:0] a;
    a = pc & ~64'd3;
    exp_addr.push_back(a);
    exp_out.push_back({pc, 32'(a)});
  endtask

  // Redirect held for one cycle; flush checked in the cycle it should appear
  task automatic redirect(input logic j, input logic b, input logic [63:0] jtv, input logic [63:0] btv);
    jump = j; branch = b; jt = jtv; bt = btv;
`ifdef IF_REDIRECT_REG_EN
    @(posedge clk); #1;
    jump = 1'b0; branch = 1'b0;
    @(negedge clk);
    check("flush_pulse", 64'(o_flush), 64'd1);
    check("no_req_on_redirect", 64'(imem.req), 64'd0);
    @(posedge clk); #1;
`else
    @(negedge clk);
    check("flush_pulse", 64'(o_flush), 64'd1);
    check("no_req_on_redirect", 64'(imem.req), 64'd0);
    @(posedge clk); #1;
    jump = 1'b0; branch = 1'b0;
`endif
  endtask

  // Monitor: compare every granted request and every consumed IF/ID output
  always @(negedge clk) begin
    logic [95:0] e;
    if (rst_n) begin
      if (imem.req && imem.gnt) begin
        gnt_cyc.push_back(cyc);
        if (exp_addr.size() == 0) check("unexpected_request", imem.addr, 64'hx);
        else check("imem_addr", imem.addr, exp_addr.pop_front());
      end
      if (o_if_valid && !i_stall && !o_flush) begin
        if (exp_out.size() == 0) begin
          check("unexpected_delivery", o_if_pc, 64'hx);
        end else begin
          e = exp_out.pop_front();
          check("if_pc", o_if_pc, e[95:32]);
          check("if_instr", 64'(o_if_instr), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    // Reset state
    step(3);
    @(negedge clk);
    check("rst_if_valid", 64'(o_if_valid), 64'd0);
    check("rst_if_pc", o_if_pc, 64'd0);
    check("rst_if_instr", 64'(o_if_instr), 64'd0);
    check("rst_flush", 64'(o_flush), 64'd0);
    check("rst_addr", imem.addr, RESET_PC_DEF);

    // Streaming with a 1-cycle memory
    allow = 3; lat = 1;
    expect_fetch(64'h8000_0000);
    expect_fetch(64'h8000_0004);
    expect_fetch(64'h8000_0008);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_valid", 64'(o_if_valid), 64'd1);
      step(1);
    end
    @(negedge clk);
    check("stream_valid_drop", 64'(o_if_valid), 64'd0);
    check("gnt_gap1", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd1);
    check("gnt_gap2", 64'(gnt_cyc[2] - gnt_cyc[1]), 64'd1);
    step(1);

    // Branch while WAIT with response pending: squashed response drained
    allow += 2; lat = 3;
    exp_addr.push_back(64'h8000_000C);
    expect_fetch(64'h8000_0100);
    step(1);
    redirect(1'b0, 1'b1, 64'h0, 64'h8000_0100);
    step(8);

    // Stall for three cycles while a response arrives
    allow += 2; lat = 1;
    expect_fetch(64'h8000_0104);
    expect_fetch(64'h8000_0108);
    step(2);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(o_if_valid), 64'd1);
      check("stall_pc", o_if_pc, 64'h8000_0104);
      check("stall_instr", 64'(o_if_instr), 64'h8000_0104);
      step(1);
    end
    i_stall = 1'b0;
    step(1);
    @(negedge clk);
    check("unstall_pc", o_if_pc, 64'h8000_0108);
    check("unstall_valid", 64'(o_if_valid), 64'd1);
    step(2);

    // Jump and branch together: jump wins
    redirect(1'b1, 1'b1, 64'h200, 64'h300);
    allow += 1;
    expect_fetch(64'h200);
    step(4);

    // JALR target with bit0 set
    redirect(1'b1, 1'b0, 64'h8000_0011, 64'h0);
    allow += 1;
    expect_fetch(64'h8000_0010);
    step(4);

    // Halfword PC: word-aligned address, PC kept as is
    redirect(1'b1, 1'b0, 64'h8000_0402, 64'h0);
    allow += 1;
    expect_fetch(64'h8000_0402);
    step(4);

    // PC wraps modulo 2^64
    redirect(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    allow += 2;
    expect_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    expect_fetch(64'h0);
    step(5);

    // Redirect in the same cycle as the response: response discarded
    allow += 1; lat = 1;
    exp_addr.push_back(64'h4);
    step(1);
    redirect(1'b0, 1'b1, 64'h0, 64'h8000_0500);
    allow += 1;
    expect_fetch(64'h8000_0500);
    step(4);

    // Reset in WAIT; the response arriving during reset is ignored
    allow += 1; lat = 2;
    exp_addr.push_back(64'h8000_0504);
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    allow += 1; lat = 1;
    expect_fetch(RESET_PC_DEF);
    @(negedge clk);
    check("post_rst_addr", imem.addr, RESET_PC_DEF);
    check("post_rst_req", 64'(imem.req), 64'd1);
    check("post_rst_valid", 64'(o_if_valid), 64'd0);
    step(6);

    check("addr_queue_left", 64'(exp_addr.size()), 64'd0);
    check("out_queue_left", 64'(exp_out.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
